shape_sequencer: RTL and testbench
==================================

# shape_sequencer

Scheduler that shares the single X/Y pulse output pair between the four shape generators (circle, eight, square, solid square). It debounces the 4-bit enable switches and launches the enabled generators in round-robin order, running each for a fixed number of complete traces. It inserts an idle gap between shapes and muxes the selected generator's pulses onto `pulse_x`/`pulse_y`. It sits between the raw board switches, the generator bank and the X/Y pulse drivers.

## Interface
- `DEB_CYCLES`, 50000: cycles an input pattern must stay stable before it is accepted (1 ms at 50 MHz).
- `REPEAT`, 4: complete traces per shape turn, ≥1.
- `GAP_CYCLES`, 1000: idle cycles between shape turns, ≥1.
- `WDOG_CYCLES`, 16777215: RUN-state timeout. Only used with the watchdog macro.

Ports:
- `sysclk`  in  1  system clock; all logic on rising edge.
- `sysrst_n`  in  1  asynchronous, active-low reset.
- `enable_sw`  in  4  raw switches: bit0 circle, bit1 eight, bit2 square, bit3 solid square.
- `gen_pulse_x`  in  4  X pulse from each generator.
- `gen_pulse_y`  in  4  Y pulse from each generator.
- `gen_done`  in  4  one-cycle pulse when a generator finishes one full trace.
- `gen_start`  out  4  one-hot, one-cycle launch strobe to a generator.
- `pulse_x`  out  1  registered muxed X pulse.
- `pulse_y`  out  1  registered muxed Y pulse.
- `active_sel`  out  2  index of the shape currently owning the outputs.
- `busy`  out  1  high in START, RUN and GAP.
- `timeout`  out  1  sticky watchdog flag.

## Operation
- **Input conditioning:** `enable_sw` passes through a 2-FF synchronizer.
  - If the synchronized value differs from the candidate: load candidate, clear counter.
  - Otherwise increment counter. On reaching `DEB_CYCLES-1`, `sw_q` <= candidate.
- **Round-robin pick:** search starts at `(last+1) mod 4` and selects the first set bit of `sw_q`. `last` <= pick.
- **IDLE:** all outputs low. If `sw_q != 0`: pick, go to START.
- **START:** one cycle. `gen_start[sel]=1`. Go to RUN. `pass_cnt` is cleared on entry from IDLE/GAP.
- **RUN:** outputs follow `gen_pulse_x/y[sel]`. `gen_done` on non-selected bits is ignored. On `gen_done[sel]`:
  - If `pass_cnt == REPEAT-1`, or `sw_q[sel] == 0`: go to GAP.
  - Otherwise `pass_cnt++`, go to START.
- **GAP:** outputs low for `GAP_CYCLES` cycles. Then:
  - If `sw_q == 0`: go to IDLE.
  - Otherwise pick and go to START.
- **Mid-turn disable:** clearing the selected switch mid-turn finishes the current trace, then abandons the remaining repeats.
- **Single switch enabled:** that shape is reselected each turn, with a GAP between turns.
- **Mid-turn enable:** a newly enabled switch is only considered at the next pick.

## Timing
- **Reset values:**
  - All outputs 0.
  - FSM = IDLE, `last` = 3, so the first pick starts at bit 0.
  - `sw_q` = 0, all counters 0.
- **Reset mid-operation:** forces the reset state immediately. Generators are not notified.
- **Switch latency:** 2 sync cycles + `DEB_CYCLES` from a stable raw change to `sw_q` update.
- **Launch latency:** IDLE→START is the cycle after `sw_q` becomes nonzero. `gen_start` is a registered output, high exactly one cycle, during START.
- **Pulse latency:** `pulse_x/y` at cycle t+1 equal `gen_pulse_x/y[sel]` at cycle t while in RUN. They are forced 0 otherwise.
- **Done to next action:** `gen_done[sel]` causes a state change on the next edge.
- **`active_sel`:** updates on entry to START and holds until the next pick.

## Configuration
- **`SHAPE_SEQ_WATCHDOG_EN` defined:**
  - A RUN counter clears on START and on `gen_done[sel]`.
  - When it reaches `WDOG_CYCLES`: set `timeout`, go to GAP.
  - `timeout` clears only on reset.
- **Not defined:** no counter is built, `timeout` is tied 0, and RUN waits for `gen_done` indefinitely.

## Test plan
Parameters: `DEB_CYCLES`=4, `REPEAT`=2, `GAP_CYCLES`=3, `WDOG_CYCLES`=20.

- **Debounce:** `enable_sw`=4'b0001 for 3 cycles, then 0 → no `gen_start`. Held 6+ cycles → `gen_start`=4'b0001 once, `busy`=1.
- **Round-robin with repeats:** `enable_sw`=4'b1010, done pulses after each start → start sequence bit1, bit1, (gap 3 cycles), bit3, bit3, bit1. `pulse_x/y` track the selected generator with 1-cycle lag and are 0 during the gap.
- **Early stop:** clear bit1 during bit1's first trace → that trace completes, then GAP, then bit3 (no second bit1 pass). Then all switches off → IDLE, `busy`=0.
- **Stray done:** `gen_done`=4'b0100 while sel=1 → ignored, FSM stays in RUN.
- **Reset:** assert `sysrst_n`=0 during RUN → all outputs 0 immediately. After release, the first pick is the lowest enabled bit.
- **Watchdog (`SHAPE_SEQ_WATCHDOG_EN`):** withhold `gen_done` for 20 cycles → `timeout`=1, GAP entered, and `timeout` stays 1 until reset. Without the macro: `timeout`=0 and FSM stays in RUN.

Source files
------------

// File: rtl/shape_sequencer.sv
// Round-robin scheduler sharing one X/Y pulse pair between four shape generators.
// Optional RUN watchdog enabled by defining SHAPE_SEQ_WATCHDOG_EN.
module shape_sequencer #(
  parameter int DEB_CYCLES  = 50000,
  parameter int REPEAT      = 4,
  parameter int GAP_CYCLES  = 1000,
  parameter int WDOG_CYCLES = 16777215
) (
  input  logic       sysclk,
  input  logic       sysrst_n,
  input  logic [3:0] enable_sw,
  input  logic [3:0] gen_pulse_x,
  input  logic [3:0] gen_pulse_y,
  input  logic [3:0] gen_done,
  output logic [3:0] gen_start,
  output logic       pulse_x,
  output logic       pulse_y,
  output logic [1:0] active_sel,
  output logic       busy,
  output logic       timeout
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int PW = $clog2(REPEAT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [PW-1:0] PASS_LAST = PW'(REPEAT - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, START, RUN, GAP} state_t;

  state_t          state, state_n;
  logic [3:0]      sync1, sync2, cand, sw_q;
  logic [DW-1:0]   deb_cnt;
  logic            deb_hit;
  logic [1:0]      sel, last, pick;
  logic [PW-1:0]   pass_cnt;
  logic [GW-1:0]   gap_cnt;
  logic            sel_done, pick_now, wdog_expire;
  logic [3:0]      gen_start_d;
  logic            pulse_x_d, pulse_y_d;

  // The accepting update lands on the same edge the counter reaches DEB_CYCLES-1.
  assign deb_hit = (int'(deb_cnt) + 2 >= DEB_CYCLES);

  always_ff @(posedge sysclk or negedge sysrst_n) begin
    if (!sysrst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      cand    <= '0;
      deb_cnt <= '0;
      sw_q    <= '0;
    end else begin
      sync1 <= enable_sw;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand    <= sync2;
        deb_cnt <= '0;
      end else begin
        if (deb_cnt != DEB_LAST) deb_cnt <= deb_cnt + 1'b1;
        if (deb_hit) sw_q <= cand;
      end
    end
  end

  // Later loop iterations override earlier ones, so last+1 has top priority.
  always_comb begin
    logic [1:0] idx;
    pick = last;
    for (int i = 4; i >= 1; i--) begin
      idx = last + 2'(i);
      if (sw_q[idx]) pick = idx;
    end
  end

  assign sel_done = gen_done[sel];

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (|sw_q) state_n = START;
      START: state_n = RUN;
      RUN: begin
        if (sel_done)
          state_n = ((pass_cnt == PASS_LAST) || !sw_q[sel]) ? GAP : START;
        else if (wdog_expire)
          state_n = GAP;
      end
      GAP:   if (gap_cnt == GAP_LAST) state_n = (|sw_q) ? START : IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign pick_now = ((state == IDLE) || (state == GAP)) && (state_n == START);

  always_ff @(posedge sysclk or negedge sysrst_n) begin
    if (!sysrst_n) begin
      state    <= IDLE;
      sel      <= 2'd0;
      last     <= 2'd3;
      pass_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      state   <= state_n;
      gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
      if (pick_now) begin
        sel      <= pick;
        last     <= pick;
        pass_cnt <= '0;
      end else if ((state == RUN) && (state_n == START)) begin
        pass_cnt <= pass_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    gen_start_d = '0;
    if (state_n == START) gen_start_d = 4'b0001 << (pick_now ? pick : sel);
    pulse_x_d = (state == RUN) && gen_pulse_x[sel];
    pulse_y_d = (state == RUN) && gen_pulse_y[sel];
  end

  always_ff @(posedge sysclk or negedge sysrst_n) begin
    if (!sysrst_n) begin
      gen_start <= '0;
      pulse_x   <= 1'b0;
      pulse_y   <= 1'b0;
    end else begin
      gen_start <= gen_start_d;
      pulse_x   <= pulse_x_d;
      pulse_y   <= pulse_y_d;
    end
  end

  assign active_sel = sel;
  assign busy       = (state != IDLE);

`ifdef SHAPE_SEQ_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);

  logic [WW-1:0] wdog_cnt;
  logic          timeout_q;

  // A completed trace wins over an expiry landing on the same cycle.
  assign wdog_expire = (state == RUN) && !sel_done && (wdog_cnt == WDOG_LAST);

  always_ff @(posedge sysclk or negedge sysrst_n) begin
    if (!sysrst_n) begin
      wdog_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if ((state == START) || sel_done) wdog_cnt <= '0;
      else if (state == RUN)            wdog_cnt <= wdog_cnt + 1'b1;
      if (wdog_expire) timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  assign wdog_expire = 1'b0;
  assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_shape_sequencer.sv
// Directed bench for shape_sequencer: debounce, round-robin repeats, early stop,
// stray done, watchdog (both builds) and asynchronous reset.
module tb_shape_sequencer;

  logic       sysclk = 1'b0;
  logic       sysrst_n;
  logic [3:0] enable_sw, gen_pulse_x, gen_pulse_y, gen_done;
  logic [3:0] gen_start;
  logic       pulse_x, pulse_y, busy, timeout;
  logic [1:0] active_sel;

  int n_checks = 0;
  int n_fail   = 0;

  shape_sequencer #(
    .DEB_CYCLES (4),
    .REPEAT     (2),
    .GAP_CYCLES (3),
    .WDOG_CYCLES(20)
  ) dut (
    .sysclk     (sysclk),
    .sysrst_n   (sysrst_n),
    .enable_sw  (enable_sw),
    .gen_pulse_x(gen_pulse_x),
    .gen_pulse_y(gen_pulse_y),
    .gen_done   (gen_done),
    .gen_start  (gen_start),
    .pulse_x    (pulse_x),
    .pulse_y    (pulse_y),
    .active_sel (active_sel),
    .busy       (busy),
    .timeout    (timeout)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    logic [3:0] en, px, py, done;
    int         cycles;
    logic [3:0] gs;
    logic       pxo, pyo;
    logic [1:0] sel;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [3:0] en, logic [3:0] px, logic [3:0] py,
                              logic [3:0] done, int cycles, logic [3:0] gs,
                              logic pxo, logic pyo, logic [1:0] sel, logic b);
    vec_t v;
    v.en = en; v.px = px; v.py = py; v.done = done; v.cycles = cycles;
    v.gs = gs; v.pxo = pxo; v.pyo = pyo; v.sel = sel; v.busy = b;
    return v;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [3:0] en, input logic [3:0] px,
                                input logic [3:0] py, input logic [3:0] done);
    enable_sw   = en;
    gen_pulse_x = px;
    gen_pulse_y = py;
    gen_done    = done;
  endtask

  task automatic check_output(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [3:0] gs, input logic pxo,
                           input logic pyo, input logic [1:0] sel, input logic b,
                           input logic to);
    check_output({name, ".gen_start"},  gen_start,         gs);
    check_output({name, ".pulse_x"},    {3'b0, pulse_x},   {3'b0, pxo});
    check_output({name, ".pulse_y"},    {3'b0, pulse_y},   {3'b0, pyo});
    check_output({name, ".active_sel"}, {2'b0, active_sel}, {2'b0, sel});
    check_output({name, ".busy"},       {3'b0, busy},      {3'b0, b});
    check_output({name, ".timeout"},    {3'b0, timeout},   {3'b0, to});
  endtask

  logic wd_on;

  initial begin
`ifdef SHAPE_SEQ_WATCHDOG_EN
    wd_on = 1'b1;
`else
    wd_on = 1'b0;
`endif
    // en, px, py, done, cycles | gen_start, pulse_x, pulse_y, active_sel, busy
    vecs.push_back(mk(4'b1010, 4'h0, 4'h0, 4'h0, 5, 4'b0000, 0, 0, 2'd0, 0));
    vecs.push_back(mk(4'b1010, 4'h0, 4'h0, 4'h0, 1, 4'b0000, 0, 0, 2'd0, 0));
    vecs.push_back(mk(4'b1010, 4'h0, 4'h0, 4'h0, 1, 4'b0010, 0, 0, 2'd1, 1));
    vecs.push_back(mk(4'b1010, 4'h0, 4'h0, 4'h0, 1, 4'b0000, 0, 0, 2'd1, 1));
    vecs.push_back(mk(4'b1010, 4'b0010, 4'b1000, 4'h0, 1, 4'b0000, 1, 0, 2'd1, 1));
    vecs.push_back(mk(4'b1010, 4'b1101, 4'b0010, 4'h0, 1, 4'b0000, 0, 1, 2'd1, 1));
    vecs.push_back(mk(4'b1010, 4'h0, 4'h0, 4'b0100, 1, 4'b0000, 0, 0, 2'd1, 1));
    vecs.push_back(mk(4'b1010, 4'b0010, 4'b0010, 4'h0, 1, 4'b0000, 1, 1, 2'd1, 1));
    vecs.push_back(mk(4'b1010, 4'h0, 4'h0, 4'b0010, 1, 4'b0010, 0, 0, 2'd1, 1));
    vecs.push_back(mk(4'b1010, 4'h0, 4'h0, 4'h0, 1, 4'b0000, 0, 0, 2'd1, 1));
    vecs.push_back(mk(4'b1010, 4'h0, 4'h0, 4'b0010, 1, 4'b0000, 0, 0, 2'd1, 1));
    vecs.push_back(mk(4'b1010, 4'hF, 4'hF, 4'h0, 1, 4'b0000, 0, 0, 2'd1, 1));
    vecs.push_back(mk(4'b1010, 4'hF, 4'hF, 4'h0, 1, 4'b0000, 0, 0, 2'd1, 1));
    vecs.push_back(mk(4'b1010, 4'h0, 4'h0, 4'h0, 1, 4'b1000, 0, 0, 2'd3, 1));
    vecs.push_back(mk(4'b1010, 4'h0, 4'h0, 4'h0, 1, 4'b0000, 0, 0, 2'd3, 1));
    vecs.push_back(mk(4'b1010, 4'b1000, 4'h0, 4'h0, 1, 4'b0000, 1, 0, 2'd3, 1));
    vecs.push_back(mk(4'b1010, 4'h0, 4'h0, 4'b1000, 1, 4'b1000, 0, 0, 2'd3, 1));
    vecs.push_back(mk(4'b1010, 4'h0, 4'h0, 4'h0, 1, 4'b0000, 0, 0, 2'd3, 1));
    vecs.push_back(mk(4'b1010, 4'h0, 4'h0, 4'b1000, 1, 4'b0000, 0, 0, 2'd3, 1));
    vecs.push_back(mk(4'b1010, 4'h0, 4'h0, 4'h0, 2, 4'b0000, 0, 0, 2'd3, 1));
    vecs.push_back(mk(4'b1010, 4'h0, 4'h0, 4'h0, 1, 4'b0010, 0, 0, 2'd1, 1));
    vecs.push_back(mk(4'b1010, 4'h0, 4'h0, 4'h0, 1, 4'b0000, 0, 0, 2'd1, 1));
    vecs.push_back(mk(4'b1000, 4'h0, 4'h0, 4'h0, 6, 4'b0000, 0, 0, 2'd1, 1));
    vecs.push_back(mk(4'b1000, 4'h0, 4'h0, 4'b0010, 1, 4'b0000, 0, 0, 2'd1, 1));
    vecs.push_back(mk(4'b1000, 4'h0, 4'h0, 4'h0, 2, 4'b0000, 0, 0, 2'd1, 1));
    vecs.push_back(mk(4'b1000, 4'h0, 4'h0, 4'h0, 1, 4'b1000, 0, 0, 2'd3, 1));
    vecs.push_back(mk(4'b1000, 4'h0, 4'h0, 4'h0, 1, 4'b0000, 0, 0, 2'd3, 1));
    vecs.push_back(mk(4'b0000, 4'h0, 4'h0, 4'h0, 6, 4'b0000, 0, 0, 2'd3, 1));
    vecs.push_back(mk(4'b0000, 4'h0, 4'h0, 4'b1000, 1, 4'b0000, 0, 0, 2'd3, 1));
    vecs.push_back(mk(4'b0000, 4'h0, 4'h0, 4'h0, 2, 4'b0000, 0, 0, 2'd3, 1));
    vecs.push_back(mk(4'b0000, 4'h0, 4'h0, 4'h0, 1, 4'b0000, 0, 0, 2'd3, 0));

    sysrst_n = 1'b0;
    apply_stimulus(4'h0, 4'h0, 4'h0, 4'h0);
    #12;
    check_all("reset", 4'b0000, 0, 0, 2'd0, 0, 0);
    @(posedge sysclk);
    #1 sysrst_n = 1'b1;

    // Three-cycle glitch on bit0 must never launch anything.
    apply_stimulus(4'b0001, 4'h0, 4'h0, 4'h0);
    step(3);
    apply_stimulus(4'b0000, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 10; i++) begin
      step(1);
      check_output($sformatf("glitch%0d.gen_start", i), gen_start, 4'b0000);
      check_output($sformatf("glitch%0d.busy", i), {3'b0, busy}, 4'b0000);
    end

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].en, vecs[i].px, vecs[i].py, vecs[i].done);
      step(vecs[i].cycles);
      check_all($sformatf("vec%0d", i), vecs[i].gs, vecs[i].pxo, vecs[i].pyo,
                vecs[i].sel, vecs[i].busy, 1'b0);
    end

    // Watchdog: bit0 runs with gen_done withheld.
    apply_stimulus(4'b0011, 4'h0, 4'h0, 4'h0);
    step(6);
    check_output("wd_idle.busy", {3'b0, busy}, 4'b0000);
    step(1);
    check_all("wd_start", 4'b0001, 0, 0, 2'd0, 1, 0);
    step(1);
    apply_stimulus(4'b0011, 4'b0001, 4'h0, 4'h0);
    step(19);
    check_all("wd_run19", 4'b0000, 1, 0, 2'd0, 1, 0);
    step(1);
    check_output("wd_run20.timeout", {3'b0, timeout}, {3'b0, wd_on});
    step(1);
    check_output("wd_after.pulse_x", {3'b0, pulse_x}, {3'b0, !wd_on});
    check_output("wd_after.busy", {3'b0, busy}, 4'b0001);
    step(2);
    check_output("wd_next.gen_start", gen_start, wd_on ? 4'b0010 : 4'b0000);
    check_output("wd_sticky.timeout", {3'b0, timeout}, {3'b0, wd_on});
    step(1);
    apply_stimulus(4'b0011, 4'hF, 4'hF, 4'h0);
    step(1);
    check_output("pre_rst.pulse_x", {3'b0, pulse_x}, 4'b0001);
    check_output("pre_rst.pulse_y", {3'b0, pulse_y}, 4'b0001);

    // Asynchronous reset mid-RUN clears outputs without waiting for an edge.
    #2 sysrst_n = 1'b0;
    #1;
    check_all("async_rst", 4'b0000, 0, 0, 2'd0, 0, 0);
    apply_stimulus(4'b0101, 4'h0, 4'h0, 4'h0);
    @(posedge sysclk);
    #1 sysrst_n = 1'b1;
    step(6);
    check_output("post_rst_idle.busy", {3'b0, busy}, 4'b0000);
    step(1);
    check_all("post_rst_start", 4'b0001, 0, 0, 2'd0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
